// File: rtl/toggle_event_receiver_if.sv
// Event link bundle between a toggle initiator/consumer pair and the receiver.
// The master drives the toggle line and consumer controls; the slave is the receiver.
interface toggle_event_receiver_if #(
    parameter int CNT_W = 8
);
    logic             T_in;
    logic             take;
    logic             clear_count;
    logic             event_pulse;
    logic             pending;
    logic             ack_toggle;
    logic             overrun;
    logic [CNT_W-1:0] event_count;

    modport master (
        output T_in, take, clear_count,
        input  event_pulse, pending, ack_toggle, overrun, event_count
    );

    modport slave (
        input  T_in, take, clear_count,
        output event_pulse, pending, ack_toggle, overrun, event_count
    );
endinterface

// File: rtl/toggle_event_receiver.sv
// Receiver for a 2-phase toggle event link: synchronises T_in, recovers one pulse per
// flip, holds it until taken, toggles an acknowledge back, counts events, flags overruns.
//
// state | meaning
// IDLE  | no event waiting (pending=0)
// HELD  | one event waiting for take (pending=1)
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset_sync,
    toggle_event_receiver_if.slave  ev
);
    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   event_pulse_q, event_pulse_d;
    logic                   ack_toggle_q, ack_toggle_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       event_count_q, event_count_d;
    logic                   edge_det;
    logic                   accept;
    logic                   lost;
    logic [CNT_W-1:0]       count_base;

    assign edge_det = sync_q[SYNC_STAGES-1] ^ prev_q;

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            prev_q        <= 1'b0;
            event_pulse_q <= 1'b0;
            ack_toggle_q  <= 1'b0;
            overrun_q     <= 1'b0;
            event_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            event_pulse_q <= event_pulse_d;
            ack_toggle_q  <= ack_toggle_d;
            overrun_q     <= overrun_d;
            event_count_q <= event_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (edge_det) state_d = HELD;
            HELD:    if (ev.take && !edge_det) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = (state_q == HELD) && ev.take;
        lost   = (state_q == HELD) && edge_det && !ev.take;

        sync_d        = {sync_q[SYNC_STAGES-2:0], ev.T_in};
        prev_d        = sync_q[SYNC_STAGES-1];
        event_pulse_d = edge_det;
        ack_toggle_d  = ack_toggle_q ^ accept;

        // An overrun in the same cycle as a clear must still be recorded.
        if (lost)
            overrun_d = 1'b1;
        else if (ev.clear_count)
            overrun_d = 1'b0;
        else
            overrun_d = overrun_q;

        count_base    = ev.clear_count ? '0 : event_count_q;
        event_count_d = count_base;
        if (edge_det && (count_base != CNT_MAX))
            event_count_d = count_base + 1'b1;
    end

    assign ev.event_pulse = event_pulse_q;
    assign ev.pending     = (state_q == HELD);
    assign ev.ack_toggle  = ack_toggle_q;
    assign ev.overrun     = overrun_q;
    assign ev.event_count = event_count_q;
endmodule

// File: tb/tb_toggle_event_receiver.sv
// Randomised bench for toggle_event_receiver with an event-level reference model
// plus directed literal checks for latency, handshake, overrun, saturation and reset.
module tb_toggle_event_receiver;
    localparam int N     = 2;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_sync;
    always #5 clk = ~clk;

    toggle_event_receiver_if #(.CNT_W(CNT_W)) ev_if ();

    toggle_event_receiver #(.SYNC_STAGES(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .ev         (ev_if.slave)
    );

    int errors = 0;
    int checks = 0;

    // reference model: history of captured T_in values, newest at index 0
    int  hist [0:N];
    int  m_pulse, m_pend, m_ack, m_ovr, m_cnt;
    bit  model_valid = 0;

    always @(posedge clk) begin
        int e;
        if (reset_sync) begin
            for (int i = 0; i <= N; i++) hist[i] = 0;
            m_pulse = 0; m_pend = 0; m_ack = 0; m_ovr = 0; m_cnt = 0;
            model_valid = 1;
        end else begin
            // a flip seen N captures ago becomes visible as an event now
            e = (hist[N-1] != hist[N]) ? 1 : 0;
            m_pulse = e;
            if (e) m_cnt = ev_if.clear_count ? 1 : ((m_cnt < MAXC) ? m_cnt + 1 : MAXC);
            else if (ev_if.clear_count) m_cnt = 0;
            if (m_pend && e && !ev_if.take) m_ovr = 1;
            else if (ev_if.clear_count) m_ovr = 0;
            if (m_pend && ev_if.take) m_ack = 1 - m_ack;
            if (e) m_pend = 1;
            else if (m_pend && ev_if.take) m_pend = 0;
            for (int i = N; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(ev_if.T_in);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_pulse",   int'(ev_if.event_pulse), m_pulse);
            check("model_pending", int'(ev_if.pending),     m_pend);
            check("model_ack",     int'(ev_if.ack_toggle),  m_ack);
            check("model_overrun", int'(ev_if.overrun),     m_ovr);
            check("model_count",   int'(ev_if.event_count), m_cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flip();
        ev_if.T_in = ~ev_if.T_in;
    endtask

    task automatic take_one();
        ev_if.take = 1'b1;
        cyc(1);
        ev_if.take = 1'b0;
    endtask

    initial begin
        int ack_before;
        reset_sync        = 1'b1;
        ev_if.T_in        = 1'b0;
        ev_if.take        = 1'b0;
        ev_if.clear_count = 1'b0;
        cyc(3);
        check("reset_pulse",   int'(ev_if.event_pulse), 0);
        check("reset_pending", int'(ev_if.pending), 0);
        check("reset_count",   int'(ev_if.event_count), 0);

        // single event: pulse exactly two clocks after capture
        reset_sync = 1'b0;
        flip();
        cyc(1); check("lat_k",    int'(ev_if.event_pulse), 0);
        cyc(1); check("lat_k1",   int'(ev_if.event_pulse), 0);
        cyc(1); check("lat_k2",   int'(ev_if.event_pulse), 1);
        check("t1_pending", int'(ev_if.pending), 1);
        check("t1_count",   int'(ev_if.event_count), 1);
        check("t1_ack",     int'(ev_if.ack_toggle), 0);
        check("t1_ovr",     int'(ev_if.overrun), 0);

        // take handshake
        take_one();
        check("t2_pulse_one_cycle", int'(ev_if.event_pulse), 0);
        check("t2_pending", int'(ev_if.pending), 0);
        check("t2_ack",     int'(ev_if.ack_toggle), 1);
        flip(); cyc(3);
        take_one();
        check("t2_count2", int'(ev_if.event_count), 2);
        check("t2_ack0",   int'(ev_if.ack_toggle), 0);
        take_one();
        check("t2_idle_take_ack", int'(ev_if.ack_toggle), 0);

        // overrun: two flips 4 apart, never taken
        flip(); cyc(4); flip(); cyc(3);
        check("t3_ovr",     int'(ev_if.overrun), 1);
        check("t3_pending", int'(ev_if.pending), 1);
        check("t3_count",   int'(ev_if.event_count), MAXC);
        check("t3_ack",     int'(ev_if.ack_toggle), 0);
        ev_if.clear_count = 1'b1; cyc(1); ev_if.clear_count = 1'b0;
        check("t3_clr_ovr", int'(ev_if.overrun), 0);
        check("t3_clr_cnt", int'(ev_if.event_count), 0);

        // take coincident with a new edge while held
        flip(); cyc(2);
        take_one();
        check("t4_pending", int'(ev_if.pending), 1);
        check("t4_ack",     int'(ev_if.ack_toggle), 1);
        check("t4_ovr",     int'(ev_if.overrun), 0);
        check("t4_count",   int'(ev_if.event_count), 1);
        take_one();

        // saturation, then clear racing an edge
        for (int i = 0; i < 5; i++) begin
            flip(); cyc(3); take_one();
        end
        check("t5_sat", int'(ev_if.event_count), MAXC);
        flip(); cyc(2);
        ev_if.clear_count = 1'b1; cyc(1); ev_if.clear_count = 1'b0;
        check("t5_clr_race", int'(ev_if.event_count), 1);
        take_one();

        // reset mid-operation with a flip in the synchroniser
        flip(); cyc(3);
        ack_before = int'(ev_if.ack_toggle);
        check("t6_pre_pending", int'(ev_if.pending), 1);
        flip(); cyc(1);
        reset_sync = 1'b1; ev_if.T_in = 1'b0;
        cyc(1);
        reset_sync = 1'b0;
        check("t6_pending", int'(ev_if.pending), 0);
        check("t6_ack",     int'(ev_if.ack_toggle), 0);
        check("t6_count",   int'(ev_if.event_count), 0);
        check("t6_ovr",     int'(ev_if.overrun), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("t6_no_pulse", int'(ev_if.event_pulse), 0);
        end
        if (ack_before > 1) check("t6_ack_range", ack_before, 1);

        // randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_sync = 1'b1; ev_if.T_in = 1'b0;
            end else begin
                reset_sync = 1'b0;
                if ($urandom_range(0, 2) == 0) flip();
            end
            ev_if.take        = ($urandom_range(0, 1) == 1);
            ev_if.clear_count = ($urandom_range(0, 15) == 0);
            cyc(1);
        end
        reset_sync = 1'b0; ev_if.take = 1'b0; ev_if.clear_count = 1'b0;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
